prv_trap_sequencer: RTL

Sequences machine-mode trap entry and `mret` return for the privilege block. It consumes the exception, return and `pipe_clear` signals driven by the hazard unit, together with the pending interrupt lines. It prioritises these into a single trap cause, waits for the pipeline to drain, then commits `mepc`, `mcause`, `mtval` and `mstatus` updates to the CSR file. Finally it drives `insert_pc` and `priv_pc` back to the hazard unit to redirect fetch.

---
 rtl/prv_trap_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/prv_trap_sequencer.sv
// Machine-mode trap entry / mret sequencer: prioritises exceptions, interrupts and
// returns, waits for the pipeline to drain, then strobes CSR updates and a fetch redirect.
module prv_trap_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fault_insn,
  input  logic        mal_insn,
  input  logic        illegal_insn,
  input  logic        breakpoint,
  input  logic        env_m,
  input  logic        mal_l,
  input  logic        mal_s,
  input  logic        fault_l,
  input  logic        fault_s,
  input  logic        ex_rmgmt,
  input  logic        prot_fault_i,
  input  logic        prot_fault_l,
  input  logic        prot_fault_s,
  input  logic        ret,
  input  logic        pipe_clear,
  input  logic [31:0] epc,
  input  logic [31:0] badaddr,
  input  logic        ext_int,
  input  logic        soft_int,
  input  logic        timer_int,
  input  logic        mstatus_mie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc_r,
  output logic        intr,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic        mepc_we,
  output logic [31:0] mepc_wdata,
  output logic        mcause_we,
  output logic [31:0] mcause_wdata,
  output logic        mtval_we,
  output logic [31:0] mtval_wdata,
  output logic        mstatus_push,
  output logic        mstatus_pop,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_CLEAR = 3'd1,
    COMMIT     = 3'd2,
    RET_COMMIT = 3'd3,
    REDIRECT   = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cause_q, epc_q, tval_q, target_q, target_nxt;
  logic        int_q, ret_q;

  logic        f_insn, f_l, f_s, exc, take_int, take_ret, req;
  logic [4:0]  exc_code, int_code;
  logic [31:0] tval_sel, base;

  always_comb begin
    f_insn   = fault_insn | prot_fault_i;
    f_l      = fault_l | prot_fault_l;
    f_s      = fault_s | prot_fault_s;
    exc      = 1'b1;
    exc_code = 5'd0;
    if      (f_insn)       exc_code = 5'd1;
    else if (mal_insn)     exc_code = 5'd0;
    else if (illegal_insn) exc_code = 5'd2;
    else if (breakpoint)   exc_code = 5'd3;
    else if (env_m)        exc_code = 5'd11;
    else if (mal_l)        exc_code = 5'd4;
    else if (mal_s)        exc_code = 5'd6;
    else if (f_l)          exc_code = 5'd5;
    else if (f_s)          exc_code = 5'd7;
    else if (ex_rmgmt)     exc_code = 5'd24;
    else                   exc      = 1'b0;

    int_code = ext_int ? 5'd11 : (soft_int ? 5'd3 : 5'd7);
    take_int = !exc && mstatus_mie && (ext_int || soft_int || timer_int);
    take_ret = !exc && !take_int && ret;
    req      = exc || take_int || take_ret;

    // Address-type faults report badaddr, breakpoints report their own PC.
    tval_sel = 32'd0;
    if (exc) begin
      case (exc_code)
        5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd6, 5'd7: tval_sel = badaddr;
        5'd3:                                      tval_sel = epc;
        default:                                   tval_sel = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    target_nxt = target_q;
    base       = mtvec & 32'hFFFF_FFFC;
    case (state)
      IDLE:       if (req) state_nxt = WAIT_CLEAR;
      WAIT_CLEAR: if (pipe_clear) state_nxt = ret_q ? RET_COMMIT : COMMIT;
      COMMIT: begin
        state_nxt  = REDIRECT;
        // Only interrupts are vectored; modes 2 and 3 fall back to direct.
        target_nxt = (int_q && mtvec[1:0] == 2'b01) ?
                     base + {25'd0, cause_q[4:0], 2'b00} : base;
      end
      RET_COMMIT: begin
        state_nxt  = REDIRECT;
        target_nxt = mepc_r & 32'hFFFF_FFFC;
      end
      REDIRECT:   state_nxt = IDLE;
      default: begin
        state_nxt  = IDLE;
        target_nxt = RESET_VECTOR;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cause_q  <= 32'd0;
      epc_q    <= 32'd0;
      tval_q   <= 32'd0;
      target_q <= 32'd0;
      int_q    <= 1'b0;
      ret_q    <= 1'b0;
    end else begin
      target_q <= target_nxt;
      if (state == IDLE && req) begin
        int_q   <= take_int;
        ret_q   <= take_ret;
        cause_q <= take_int ? {1'b1, 26'd0, int_code} :
                   (exc ? {1'b0, 26'd0, exc_code} : 32'd0);
        epc_q   <= epc;
        tval_q  <= tval_sel;
      end
    end
  end

  assign busy         = (state != IDLE);
  assign intr         = busy && int_q;
  assign mepc_we      = (state == COMMIT);
  assign mcause_we    = (state == COMMIT);
  assign mtval_we     = (state == COMMIT);
  assign mstatus_push = (state == COMMIT);
  assign mstatus_pop  = (state == RET_COMMIT);
  assign insert_pc    = (state == REDIRECT);
  assign priv_pc      = target_q;
  assign mepc_wdata   = epc_q;
  assign mcause_wdata = cause_q;
  assign mtval_wdata  = tval_q;

endmodule
